// File: rtl/quasi_aclint_pkg.sv
// Shared address map and bus byte-order helper for the multi-hart ACLINT.
package quasi_aclint_pkg;

  localparam logic [15:0] ACLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] ACLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] ACLINT_MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] ACLINT_MTIME_HI      = 16'hBFFC;
  localparam logic [15:0] ACLINT_SSWI_BASE     = 16'hC000;
  localparam int unsigned ACLINT_MAX_HARTS     = 16;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/aclint_prescaler.sv
// Phase-accumulator prescaler: tick averages exactly TIMER_RATE per second of clk.
module aclint_prescaler #(
  parameter int unsigned CLOCK_FREQ = 62500000,
  parameter int unsigned TIMER_RATE = 10000000,
  parameter int unsigned ACC_W      = 32
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [ACC_W:0] W_RATE = (ACC_W+1)'(TIMER_RATE);
  localparam logic [ACC_W:0] W_FREQ = (ACC_W+1)'(CLOCK_FREQ);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_wrap;

  always_comb begin
    w_sum  = {1'b0, r_acc} + W_RATE;
    w_wrap = w_sum - W_FREQ;
    tick   = (w_sum >= W_FREQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (tick) begin
      r_acc <= w_wrap[ACC_W-1:0];
    end else begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/aclint_mh.sv
// Multi-hart ACLINT: per-hart MSIP/MTIMECMP/SSWI, one shared 64-bit MTIME.
module aclint_mh
  import quasi_aclint_pkg::*;
#(
  parameter int unsigned N_HARTS    = 1,
  parameter int unsigned CLOCK_FREQ = 62500000,
  parameter int unsigned TIMER_RATE = 10000000,
  parameter int unsigned ACC_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic [31:0]        d,
  input  logic               we,
  output logic [31:0]        spo,
  output logic [N_HARTS-1:0] s_irq,
  output logic [N_HARTS-1:0] t_irq,
  output logic [N_HARTS-1:0] ssip_set
);

  localparam int unsigned HIDX_W    = $clog2(ACLINT_MAX_HARTS);
  localparam logic [15:0] W_SPAN4   = 16'(4 * N_HARTS);
  localparam logic [15:0] W_SPAN8   = 16'(8 * N_HARTS);

  logic [31:0] w_data;
  logic [15:0] w_word;
  logic [15:0] w_msip_off, w_cmp_off, w_sswi_off;
  logic        w_msip_hit, w_cmp_hit, w_sswi_hit, w_cmp_hi;
  logic        w_mtlo_sel, w_mthi_sel, w_tick, w_carry;
  logic [N_HARTS-1:0] w_msip_sel, w_cmp_sel, w_sswi_sel;
  logic [31:0] w_rd;

  logic [N_HARTS-1:0] r_msip, r_tirq, r_ssip;
  logic [31:0]        r_cmpl [N_HARTS];
  logic [31:0]        r_cmph [N_HARTS];
  logic [31:0]        r_mtimel, r_mtimeh;

  aclint_prescaler #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .TIMER_RATE (TIMER_RATE),
    .ACC_W      (ACC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Offsets wrap below each base, so a single unsigned "< span" test bounds both ends.
  always_comb begin
    w_data     = bswap32(d);
    w_word     = a & 16'hFFFC;
    w_msip_off = w_word - ACLINT_MSIP_BASE;
    w_cmp_off  = w_word - ACLINT_MTIMECMP_BASE;
    w_sswi_off = w_word - ACLINT_SSWI_BASE;
    w_msip_hit = (w_msip_off < W_SPAN4);
    w_cmp_hit  = (w_cmp_off < W_SPAN8);
    w_sswi_hit = (w_sswi_off < W_SPAN4);
    w_cmp_hi   = w_cmp_off[2];
    w_mtlo_sel = (w_word == ACLINT_MTIME_LO);
    w_mthi_sel = (w_word == ACLINT_MTIME_HI);
    w_carry    = w_tick && (r_mtimel == '1) && !(we && w_mtlo_sel);
  end

  for (genvar h = 0; h < N_HARTS; h++) begin : g_sel
    assign w_msip_sel[h] = w_msip_hit && (w_msip_off[HIDX_W+1:2] == HIDX_W'(h));
    assign w_cmp_sel[h]  = w_cmp_hit  && (w_cmp_off[HIDX_W+2:3]  == HIDX_W'(h));
    assign w_sswi_sel[h] = w_sswi_hit && (w_sswi_off[HIDX_W+1:2] == HIDX_W'(h));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimel <= '0;
      r_mtimeh <= '0;
    end else begin
      if (we && w_mtlo_sel) begin
        r_mtimel <= w_data;
      end else begin
        r_mtimel <= r_mtimel + 32'(w_tick);
      end
      if (we && w_mthi_sel) begin
        r_mtimeh <= w_data;
      end else if (w_carry) begin
        r_mtimeh <= r_mtimeh + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msip <= '0;
      r_tirq <= '0;
      r_ssip <= '0;
      for (int unsigned h = 0; h < N_HARTS; h++) begin
        r_cmpl[h] <= '1;
        r_cmph[h] <= '1;
      end
    end else begin
      for (int unsigned h = 0; h < N_HARTS; h++) begin
        if (we && w_msip_sel[h]) r_msip[h] <= w_data[0];
        if (we && w_cmp_sel[h] && !w_cmp_hi) r_cmpl[h] <= w_data;
        if (we && w_cmp_sel[h] && w_cmp_hi)  r_cmph[h] <= w_data;
        r_tirq[h] <= ({r_mtimeh, r_mtimel} >= {r_cmph[h], r_cmpl[h]});
        r_ssip[h] <= we && w_sswi_sel[h] && w_data[0];
      end
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_mtlo_sel) w_rd = r_mtimel;
    if (w_mthi_sel) w_rd = r_mtimeh;
    for (int unsigned h = 0; h < N_HARTS; h++) begin
      if (w_msip_sel[h]) w_rd = {31'b0, r_msip[h]};
      if (w_cmp_sel[h])  w_rd = w_cmp_hi ? r_cmph[h] : r_cmpl[h];
    end
    spo = bswap32(w_rd);
  end

  assign s_irq    = r_msip;
  assign t_irq    = r_tirq;
  assign ssip_set = r_ssip;

endmodule

// File: tb/tb_aclint_mh.sv
// Randomized scoreboard bench for aclint_mh against a behavioural ACLINT model.
module tb_aclint_mh;

  localparam int N  = 4;
  localparam int CF = 25;
  localparam int TR = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [15:0] a   = '0;
  logic [31:0] d   = '0;
  logic [31:0] spo;
  logic [N-1:0] s_irq, t_irq, ssip_set;

  always #5 clk = ~clk;

  aclint_mh #(
    .N_HARTS    (N),
    .CLOCK_FREQ (CF),
    .TIMER_RATE (TR),
    .ACC_W      (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .d        (d),
    .we       (we),
    .spo      (spo),
    .s_irq    (s_irq),
    .t_irq    (t_irq),
    .ssip_set (ssip_set)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]  spo;
    logic [N-1:0] s;
    logic [N-1:0] t;
    logic [N-1:0] ss;
  } exp_t;
  exp_t q[$];
  bit   mon_en = 1'b0;

  // Reference model state
  longint unsigned n_edges;
  logic [63:0]     m_time;
  logic [63:0]     m_cmp [N];
  logic [N-1:0]    m_msip, m_t, m_ss;

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Ideal rate: edge n carries a tick when floor(n*TR/CF) steps up.
  function automatic bit tick_at(input longint unsigned n);
    return ((n * TR) / CF) != (((n - 1) * TR) / CF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    n_edges = 0;
    m_time  = '0;
    m_msip  = '0;
    m_t     = '0;
    m_ss    = '0;
    for (int h = 0; h < N; h++) m_cmp[h] = '1;
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] addr);
    int w;
    int h;
    w = int'(addr) & 32'hFFFC;
    if (w < 4 * N) return {31'b0, m_msip[w / 4]};
    if (w >= 'h4000 && w < 'h4000 + 8 * N) begin
      h = (w - 'h4000) / 8;
      return (((w - 'h4000) % 8) != 0) ? m_cmp[h][63:32] : m_cmp[h][31:0];
    end
    if (w == 'hBFF8) return m_time[31:0];
    if (w == 'hBFFC) return m_time[63:32];
    return '0;
  endfunction

  task automatic m_step(input bit w, input logic [15:0] addr, input logic [31:0] data);
    int          wa;
    int          h;
    logic [63:0] inc;
    logic [N-1:0] t_n;
    logic [N-1:0] ss_n;
    n_edges++;
    for (int i = 0; i < N; i++) t_n[i] = (m_time >= m_cmp[i]);
    ss_n = '0;
    inc  = m_time + (tick_at(n_edges) ? 64'd1 : 64'd0);
    wa   = int'(addr) & 32'hFFFC;
    if (w && wa == 'hBFF8)      m_time = {m_time[63:32], data};
    else if (w && wa == 'hBFFC) m_time = {data, inc[31:0]};
    else                        m_time = inc;
    if (w) begin
      if (wa < 4 * N) m_msip[wa / 4] = data[0];
      if (wa >= 'h4000 && wa < 'h4000 + 8 * N) begin
        h = (wa - 'h4000) / 8;
        if (((wa - 'h4000) % 8) != 0) m_cmp[h][63:32] = data;
        else                          m_cmp[h][31:0]  = data;
      end
      if (wa >= 'hC000 && wa < 'hC000 + 4 * N) ss_n[(wa - 'hC000) / 4] = data[0];
    end
    m_t  = t_n;
    m_ss = ss_n;
  endtask

  // Entered #1 after a posedge; leaves #1 after the next posedge.
  task automatic cycle(input bit w, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    we = w;
    a  = addr;
    d  = swap(data);
    e.spo = swap(m_read(addr));
    e.s   = m_msip;
    e.t   = m_t;
    e.ss  = m_ss;
    q.push_back(e);
    m_step(w, addr, data);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("spo", spo, e.spo);
      chk("s_irq", 32'(s_irq), 32'(e.s));
      chk("t_irq", 32'(t_irq), 32'(e.t));
      chk("ssip_set", 32'(ssip_set), 32'(e.ss));
    end
  end

  function automatic logic [15:0] rnd_addr();
    int h;
    h = int'($urandom_range(0, N));
    case ($urandom % 7)
      0: return 16'(4 * h + int'($urandom % 4));
      1, 2: return 16'('h4000 + 8 * h + 4 * int'($urandom % 2));
      3: return 16'hBFF8;
      4: return 16'hBFFC;
      5: return 16'('hC000 + 4 * h);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom % 4)
      0: return $urandom % 64;
      1: return 32'hFFFF_FFF0 + ($urandom % 16);
      2: return $urandom % 2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          last_edge;
    int          exp_gap;
    logic [31:0] prev;
    logic [31:0] cur;

    m_reset();
    #12;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state and prescaler cadence
    chk("rst_t_irq", 32'(t_irq), 32'd0);
    chk("rst_s_irq", 32'(s_irq), 32'd0);
    prev = 32'd0;
    last_edge = 0;
    exp_gap = 2;
    for (int i = 1; i <= 250; i++) begin
      cycle(1'b0, 16'hBFF8, 32'd0);
      cur = swap(spo);
      if (cur != prev) begin
        if (last_edge != 0) begin
          chk("tick_gap", 32'(i - last_edge), 32'(exp_gap));
          exp_gap = (exp_gap == 2) ? 3 : 2;
        end else begin
          chk("first_tick", 32'(i), 32'd3);
        end
        last_edge = i;
        prev = cur;
      end
    end
    we = 1'b0;
    a  = 16'hBFF8;
    #1;
    chk("mtime_250", spo, swap(32'd100));

    // Carry from low into high
    cycle(1'b1, 16'hBFFC, 32'd0);
    while (tick_at(n_edges + 1)) cycle(1'b0, 16'hBFFC, 32'd0);
    cycle(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'hBFFC, 32'd0);

    // Low-half write on a tick edge with old low all ones: no carry
    cycle(1'b1, 16'hBFFC, 32'd0);
    while (!(tick_at(n_edges + 2) && !tick_at(n_edges + 1))) cycle(1'b0, 16'hBFFC, 32'd0);
    cycle(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    cycle(1'b1, 16'hBFF8, 32'h1234_5678);
    cycle(1'b0, 16'hBFFC, 32'd0);
    cycle(1'b0, 16'hBFF8, 32'd0);

    // Timer compare on hart 2
    cycle(1'b1, 16'h4014, 32'd0);
    cycle(1'b1, 16'h4010, 32'd5);
    cycle(1'b1, 16'hBFFC, 32'd0);
    cycle(1'b1, 16'hBFF8, 32'd0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'hBFF8, 32'd0);
    cycle(1'b1, 16'h4014, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h4014, 32'd0);

    // MSIP and SSWI
    cycle(1'b1, 16'h000C, 32'd1);
    cycle(1'b0, 16'h000C, 32'd0);
    cycle(1'b1, 16'hC004, 32'd1);
    cycle(1'b0, 16'hC004, 32'd0);
    cycle(1'b1, 16'hC008, 32'd0);
    cycle(1'b1, 16'hC000, 32'd1);
    cycle(1'b1, 16'hC000, 32'd1);
    cycle(1'b0, 16'h0000, 32'd0);

    // Byte order and out-of-range harts
    cycle(1'b1, 16'h4000, 32'h1234_5678);
    cycle(1'b0, 16'h4000, 32'd0);
    cycle(1'b0, 16'h4100, 32'd0);
    cycle(1'b1, 16'h0010, 32'd1);
    cycle(1'b0, 16'h0010, 32'd0);
    cycle(1'b1, 16'hC010, 32'd1);
    cycle(1'b0, 16'h4020, 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom % 3 == 0) cycle(1'b1, rnd_addr(), rnd_data());
      else                   cycle(1'b0, rnd_addr(), 32'd0);
    end

    // Async reset with live outputs
    cycle(1'b1, 16'h0000, 32'd1);
    cycle(1'b1, 16'h4004, 32'd0);
    cycle(1'b1, 16'h4000, 32'd0);
    cycle(1'b0, 16'h0000, 32'd0);
    cycle(1'b1, 16'hC000, 32'd1);
    mon_en = 1'b0;
    we = 1'b0;
    #2;
    chk("pre_rst_s_irq", 32'(s_irq), 32'(m_msip));
    chk("pre_rst_t_irq", 32'(t_irq), 32'(m_t));
    chk("pre_rst_ssip", 32'(ssip_set), 32'(m_ss));
    rst = 1'b1;
    #1;
    chk("async_s_irq", 32'(s_irq), 32'd0);
    chk("async_t_irq", 32'(t_irq), 32'd0);
    chk("async_ssip", 32'(ssip_set), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    mon_en = 1'b1;
    cycle(1'b0, 16'hBFF8, 32'd0);
    cycle(1'b0, 16'hBFFC, 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'hBFF8, 32'd0);
    cycle(1'b0, 16'h4000, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
